// File: rtl/mau_pkg.sv
// Shared types and lane helpers for the memory access unit.
// Optional feature macro: MAU_UNALIGNED_EN (enables LWL/LWR).
package mau_pkg;

    // Operation codes are the low four bits of the MIPS load/store opcode.
    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LWL = 4'd2,
        OP_LW  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd11
    } mau_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } mau_state_t;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
    localparam logic [31:0] ALL_ONES  = 32'hFFFF_FFFF;

    // Big-endian: byte k sits at bit 8*(3-k), which for a 2-bit k is {~k, 3'b000}.
    function automatic logic [4:0] byte_lsb(input logic [1:0] k);
        return {~k, 3'b000};
    endfunction

    // Halfword selected by addr[1] sits at bit 16*(1-addr[1]).
    function automatic logic [4:0] half_lsb(input logic a1);
        return {~a1, 4'b0000};
    endfunction

    // Left shift that brings byte k to the top of the word (8*k).
    function automatic logic [4:0] byte_top_shift(input logic [1:0] k);
        return {k, 3'b000};
    endfunction

endpackage

// File: rtl/mau_lane_merge.sv
// Combinational byte-lane logic: load extraction/extension, sub-word store
// merge, and the LWL/LWR combine when MAU_UNALIGNED_EN is defined.
module mau_lane_merge
    import mau_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    input  logic [31:0] rt_value,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [31:0] shifted_b;
    logic [31:0] shifted_h;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

`ifndef MAU_UNALIGNED_EN
    logic unused_rt;
    assign unused_rt = ^rt_value;
`endif

    // Select the addressed byte and halfword lanes from the memory word.
    always_comb begin
        b_sh      = byte_lsb(offset);
        h_sh      = half_lsb(offset[1]);
        shifted_b = mem_word >> b_sh;
        shifted_h = mem_word >> h_sh;
        byte_val  = shifted_b[7:0];
        half_val  = shifted_h[15:0];
    end

    // Build the load result with sign or zero extension, or the partial-word combine.
    always_comb begin
        load_data = 32'h0;
        case (op)
            OP_LB:  load_data = {{24{byte_val[7]}}, byte_val};
            OP_LBU: load_data = {24'h0, byte_val};
            OP_LH:  load_data = {{16{half_val[15]}}, half_val};
            OP_LHU: load_data = {16'h0, half_val};
            OP_LW:  load_data = mem_word;
`ifdef MAU_UNALIGNED_EN
            OP_LWL: load_data = (mem_word << byte_top_shift(offset))
                              | (rt_value & ~(ALL_ONES << byte_top_shift(offset)));
            OP_LWR: load_data = (mem_word >> b_sh)
                              | (rt_value & ~(ALL_ONES >> b_sh));
`endif
            default: load_data = 32'h0;
        endcase
    end

    // Splice the new byte or halfword into the word read back from memory.
    always_comb begin
        merged_word = mem_word;
        case (op)
            OP_SB:   merged_word = (mem_word & ~(BYTE_MASK << b_sh))
                                 | ((store_data & BYTE_MASK) << b_sh);
            OP_SH:   merged_word = (mem_word & ~(HALF_MASK << h_sh))
                                 | ((store_data & HALF_MASK) << h_sh);
            default: merged_word = mem_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-wide data port.
// Sub-word stores become read-modify-write; misaligned or unsupported ops
// respond with an error without touching memory.
// Optional feature macro: MAU_UNALIGNED_EN (enables LWL/LWR).
module mem_access_unit
    import mau_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata
);

    mau_state_t  state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_q, rt_d;
    logic        data_read_q, data_read_d;
    logic        data_write_q, data_write_d;
    logic [31:0] data_address_q, data_address_d;
    logic [31:0] data_writedata_q, data_writedata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        go_rd;
    logic        go_wr;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    mau_lane_merge u_lane_merge (
        .op          (op_q),
        .offset      (offset_q),
        .mem_word    (data_readdata),
        .store_data  (wdata_q),
        .rt_value    (rt_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    assign req_ready      = (state_q == ST_IDLE);
    assign data_read      = data_read_q;
    assign data_write     = data_write_q;
    assign data_address   = data_address_q;
    assign data_writedata = data_writedata_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;

    // Classify the incoming op: which ones read first, which write directly.
    always_comb begin
        go_rd = 1'b0;
        go_wr = 1'b0;
        case (req_op)
            OP_LB, OP_LBU:        go_rd = 1'b1;
            OP_LH, OP_LHU, OP_SH: go_rd = ~req_addr[0];
            OP_LW:                go_rd = (req_addr[1:0] == 2'b00);
            OP_SB:                go_rd = 1'b1;
            OP_SW:                go_wr = (req_addr[1:0] == 2'b00);
`ifdef MAU_UNALIGNED_EN
            OP_LWL, OP_LWR:       go_rd = 1'b1;
`endif
            default: begin
                go_rd = 1'b0;
                go_wr = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; strobes are computed one state ahead so they leave flops.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        offset_d         = offset_q;
        wdata_d          = wdata_q;
        rt_d             = rt_q;
        data_read_d      = 1'b0;
        data_write_d     = 1'b0;
        resp_valid_d     = 1'b0;
        data_address_d   = data_address_q;
        data_writedata_d = data_writedata_q;
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d         = req_op;
                    offset_d     = req_addr[1:0];
                    wdata_d      = req_wdata;
                    rt_d         = req_rt;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b0;
                    if (go_rd) begin
                        state_d        = ST_RD;
                        data_read_d    = 1'b1;
                        data_address_d = {req_addr[31:2], 2'b00};
                    end else if (go_wr) begin
                        state_d          = ST_WR;
                        data_write_d     = 1'b1;
                        data_address_d   = {req_addr[31:2], 2'b00};
                        data_writedata_d = req_wdata;
                    end else begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            ST_RD: begin
                if (op_q[3]) begin
                    state_d          = ST_WR;
                    data_write_d     = 1'b1;
                    data_writedata_d = merged_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            op_q             <= 4'h0;
            offset_q         <= 2'b00;
            wdata_q          <= 32'h0;
            rt_q             <= 32'h0;
            data_read_q      <= 1'b0;
            data_write_q     <= 1'b0;
            data_address_q   <= 32'h0;
            data_writedata_q <= 32'h0;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'h0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            offset_q         <= offset_d;
            wdata_q          <= wdata_d;
            rt_q             <= rt_d;
            data_read_q      <= data_read_d;
            data_write_q     <= data_write_d;
            data_address_q   <= data_address_d;
            data_writedata_q <= data_writedata_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized load/store traffic against a byte-addressed reference memory.
// Honours MAU_UNALIGNED_EN the same way as the design.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] mem_dut [0:63];
    logic [7:0]  ref_mem [0:255];

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap_cnt = 0;
    logic [31:0] wr_word_seen = 32'h0;
    logic [31:0] wr_addr_seen = 32'h0;

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_rt         (req_rt),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .data_address   (data_address),
        .data_read      (data_read),
        .data_write     (data_write),
        .data_writedata (data_writedata),
        .data_readdata  (data_readdata)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT: combinational read, write on the rising edge.
    assign data_readdata = mem_dut[data_address[7:2]];
    always @(posedge clk) begin
        if (data_write) mem_dut[data_address[7:2]] <= data_writedata;
    end

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_read) rd_cnt++;
        if (data_write) begin
            wr_cnt++;
            wr_word_seen = data_writedata;
            wr_addr_seen = data_address;
        end
        if (data_read && data_write) overlap_cnt++;
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setWord(input int addr, input logic [31:0] value);
        mem_dut[addr / 4] = value;
        ref_mem[addr & ~3]       = value[31:24];
        ref_mem[(addr & ~3) + 1] = value[23:16];
        ref_mem[(addr & ~3) + 2] = value[15:8];
        ref_mem[(addr & ~3) + 3] = value[7:0];
    endtask

    // Reference model: MIPS load/store semantics on a big-endian byte memory.
    task automatic modelAccess(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rt,
                               output logic [31:0] e_data, output logic e_err,
                               output int e_lat, output int e_rd, output int e_wr,
                               output logic [31:0] e_word);
        int a;
        int base;
        int k;
        logic [7:0]  b;
        logic [15:0] h;
        a      = int'(addr[7:0]);
        base   = a & ~3;
        k      = a & 3;
        e_data = 32'h0;
        e_err  = 1'b0;
        e_rd   = 1;
        e_wr   = 0;
        e_lat  = 2;
        case (op)
            4'd0: begin b = ref_mem[a]; e_data = {{24{b[7]}}, b}; end
            4'd4: e_data = {24'h0, ref_mem[a]};
            4'd1, 4'd5: begin
                if (a % 2 != 0) e_err = 1'b1;
                else begin
                    h = {ref_mem[a], ref_mem[a + 1]};
                    e_data = (op == 4'd1) ? {{16{h[15]}}, h} : {16'h0, h};
                end
            end
            4'd3: begin
                if (k != 0) e_err = 1'b1;
                else e_data = {ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]};
            end
`ifdef MAU_UNALIGNED_EN
            4'd2: begin
                e_data = rt;
                for (int i = 0; i <= 3 - k; i++) e_data[31 - 8 * i -: 8] = ref_mem[a + i];
            end
            4'd6: begin
                e_data = rt;
                for (int i = 0; i <= k; i++) e_data[8 * i +: 8] = ref_mem[a - i];
            end
`endif
            4'd8: begin
                ref_mem[a] = wdata[7:0];
                e_wr = 1; e_lat = 3;
            end
            4'd9: begin
                if (a % 2 != 0) e_err = 1'b1;
                else begin
                    ref_mem[a] = wdata[15:8]; ref_mem[a + 1] = wdata[7:0];
                    e_wr = 1; e_lat = 3;
                end
            end
            4'd11: begin
                if (k != 0) e_err = 1'b1;
                else begin
                    ref_mem[a] = wdata[31:24]; ref_mem[a + 1] = wdata[23:16];
                    ref_mem[a + 2] = wdata[15:8]; ref_mem[a + 3] = wdata[7:0];
                    e_rd = 0; e_wr = 1;
                end
            end
            default: e_err = 1'b1;
        endcase
        if (e_err) begin
            e_data = 32'h0; e_rd = 0; e_wr = 0; e_lat = 1;
        end
        e_word = {ref_mem[base], ref_mem[base + 1], ref_mem[base + 2], ref_mem[base + 3]};
    endtask

    // One full request/response transaction, called while positioned just after a falling edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rt);
        logic [31:0] e_data;
        logic [31:0] e_word;
        logic        e_err;
        int          e_lat, e_rd, e_wr;
        int          c, rd0, wr0, ov0;
        logic        got;
        logic        ready_in_resp;
        logic        pulse_after;
        modelAccess(op, addr, wdata, rt, e_data, e_err, e_lat, e_rd, e_wr, e_word);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rt    = rt;
        checkOutput("ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt; ov0 = overlap_cnt;
        got = 1'b0; c = 0; ready_in_resp = 1'b1;
        last_rdata = 32'hX; last_err = 1'bX; last_lat = 0;
        while (!got && c < 8) begin
            c++;
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; last_lat = c;
                last_rdata = resp_rdata; last_err = resp_err; ready_in_resp = req_ready;
            end
            req_valid = 1'b0;
            req_op    = 4'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_rt    = $urandom;
        end
        @(negedge clk);
        pulse_after = resp_valid;
        #1;
        checkOutput("latency", 32'(last_lat), 32'(e_lat));
        checkOutput("rdata", last_rdata, e_data);
        checkOutput("err", {31'h0, last_err}, {31'h0, e_err});
        checkOutput("ready_in_resp", {31'h0, ready_in_resp}, 32'h0);
        checkOutput("resp_one_cycle", {31'h0, pulse_after}, 32'h0);
        checkOutput("read_count", 32'(rd_cnt - rd0), 32'(e_rd));
        checkOutput("write_count", 32'(wr_cnt - wr0), 32'(e_wr));
        checkOutput("rd_wr_overlap", 32'(overlap_cnt - ov0), 32'h0);
        if (e_wr == 1) begin
            checkOutput("write_word", wr_word_seen, e_word);
            checkOutput("write_addr", wr_addr_seen, {24'h0, addr[7:2], 2'b00});
        end
    endtask

    initial begin
        int wr_before;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rt = 32'h0;
        for (int w = 0; w < 64; w++) setWord(w * 4, $urandom);
        setWord(32'h10, 32'h8899AABB);

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_strobes", {30'h0, data_read, data_write}, 32'h0);
        checkOutput("rst_address", data_address, 32'h0);
        checkOutput("rst_writedata", data_writedata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(4'd0, 32'h11, 32'h0, 32'h0);
        checkOutput("tp_lb", last_rdata, 32'hFFFFFF99);
        applyStimulus(4'd5, 32'h12, 32'h0, 32'h0);
        checkOutput("tp_lhu", last_rdata, 32'h0000AABB);
        applyStimulus(4'd1, 32'h13, 32'h0, 32'h0);
        checkOutput("tp_lh_err", {31'h0, last_err}, 32'h1);
        applyStimulus(4'd2, 32'h11, 32'h0, 32'h11223344);
`ifdef MAU_UNALIGNED_EN
        checkOutput("tp_lwl", last_rdata, 32'h99AABB44);
`else
        checkOutput("tp_lwl_err", {31'h0, last_err}, 32'h1);
`endif
        applyStimulus(4'd8, 32'h12, 32'h000000CC, 32'h0);
        checkOutput("tp_sb_word", wr_word_seen, 32'h8899CCBB);
        applyStimulus(4'd11, 32'h20, 32'hDEADBEEF, 32'h0);
        applyStimulus(4'd3, 32'h20, 32'h0, 32'h0);
        checkOutput("tp_lw", last_rdata, 32'hDEADBEEF);
        applyStimulus(4'd11, 32'h10, 32'h8899AABB, 32'h0);

        // Reset during the read cycle of a halfword store.
        req_valid = 1'b1; req_op = 4'd9; req_addr = 32'h10; req_wdata = 32'h00001234;
        @(posedge clk);
        wr_before = wr_cnt;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("mid_rst_in_rd", {31'h0, data_read}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_strobes", {30'h0, data_read, data_write}, 32'h0);
        checkOutput("mid_rst_ready", {31'h0, req_ready}, 32'h1);
        checkOutput("mid_rst_address", data_address, 32'h0);
        checkOutput("mid_rst_writedata", data_writedata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_no_write", 32'(wr_cnt - wr_before), 32'h0);
        @(negedge clk);
        applyStimulus(4'd3, 32'h10, 32'h0, 32'h0);
        checkOutput("tp_lw_after_rst", last_rdata, 32'h8899AABB);

        for (int n = 0; n < 80; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), 32'($urandom_range(0, 255)), $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU execute stage and the word-organised data memory port. It accepts one MIPS load or store per request and handles sign/zero extension. Sub-word stores become a read-modify-write sequence on the word memory. Misaligned accesses are flagged without touching memory. Byte order is big-endian: byte offset 0 is bits [31:24].

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_op  in  4  operation code, equal to MIPS opcode[3:0]: LB=0, LH=1, LWL=2, LW=3, LBU=4, LHU=5, LWR=6, SB=8, SH=9, SW=11.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (rt).
- req_rt  in  32  current rt value, used only by LWL/LWR.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; set for misaligned or unsupported op.
- data_address  out  32  word-aligned address; bits [1:0] always 0.
- data_read  out  1  memory read strobe.
- data_write  out  1  memory write strobe.
- data_writedata  out  32  full word to write.
- data_readdata  in  32  memory read data; valid at the rising edge ending a cycle with data_read=1.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE to RD on accept for: loads, or SB/SH.
- IDLE to WR on accept for: SW.
- IDLE to RESP, with err=1 and no memory strobe, on accept for:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0;
  - undefined ops.
- Request fields are registered at accept; later changes to the inputs are ignored.
- RD: data_read=1 for one cycle. Capture data_readdata at the end of the cycle.
  - Loads: compute the result, then go to RESP.
  - SB/SH: merge the new byte/half into the captured word, then go to WR.
- WR: data_write=1 for one cycle, data_writedata is the merged or SW word, then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Load extraction for offset k=addr[1:0]:
  - byte = word[31-8k -: 8];
  - half = word[31-16·addr[1] -: 16];
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Strobes, address and writedata are registered outputs driven from state. data_read and data_write are never high together.

## Timing
- Reset values: state IDLE; data_read, data_write, resp_valid, resp_err = 0; data_address, data_writedata, resp_rdata = 0. req_ready=1 during and after reset.
- Latency from the accept edge to the resp_valid cycle:
  - loads and SW: 2 cycles;
  - SB/SH: 3 cycles;
  - errors: 1 cycle.
- Back-to-back requests: the earliest next accept is the cycle after RESP.
- Reset mid-operation forces IDLE immediately and drops strobes.
  - Reset asserted before the WR rising edge: no write occurs.
  - Reset asserted during RESP: the response is lost.

## Configuration
- MAU_UNALIGNED_EN defined: LWL and LWR are supported through the RD path with 2-cycle latency. Both ignore addr[1:0] alignment. With k=addr[1:0]:
  - LWL = (word << 8k) | (rt & ((1<<8k)-1));
  - LWR = (word >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k))).
- Undefined: LWL/LWR are treated as unsupported and return err=1 with 1-cycle latency.

## Structure
- Package mau_pkg holds:
  - mau_op_t enum with the encodings above;
  - mau_state_t;
  - helper constants for byte-lane shift amounts.
- One combinational sub-module, mau_lane_merge, handles load extraction/extension, store merge, and LWL/LWR combine. The FSM and registers stay in mem_access_unit.

## Test plan
- Memory word 0x10 = 0x8899AABB; LB addr 0x11 -> resp_rdata=0xFFFFFF99, err=0, resp_valid 2 cycles after accept.
- Same word; LHU addr 0x12 -> 0x0000AABB. LH addr 0x13 -> err=1, no data_read pulse, latency 1.
- SB addr 0x12 wdata 0x000000CC -> one RD then one WR with data_writedata=0x8899CCBB, resp_valid 3 cycles after accept.
- SW addr 0x20 wdata 0xDEADBEEF, then LW 0x20 -> 0xDEADBEEF; req_ready low from accept through RESP.
- Reset pulse during the RD cycle of SH addr 0x10 -> no data_write ever, outputs at reset values, next LW 0x10 returns 0x8899AABB.
- With MAU_UNALIGNED_EN: LWL addr 0x11, rt=0x11223344 -> 0x99AABB44. Without the macro -> err=1.
